pipe_hazard_sched: RTL

//  - Pipeline hazard scheduler for the 5-stage IF/ID/EX/MEM/WR core.
//  - Tracks in-flight register writers in a 3-entry scoreboard (EX, MEM, WR).
//  - Stalls IF/ID and inserts ID/EX bubbles on RAW hazards.
//  - Sequences the flush after a taken branch resolves in EX, and drives the
//    PC increment enable that replaces the free-running inc_pc counter.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipe_hazard_sched_if.sv | 35 +++
 rtl/pipe_hazard_sched_hz_match.sv | 20 ++
 rtl/pipe_hazard_sched.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard scheduler: forwarding encodings,
// control states and the in-flight writer scoreboard entry.
package pipe_pkg;

  localparam int REG_AW_DEFAULT = 5;
  // Scoreboard entries store destinations zero-extended to this width.
  localparam int SB_AW = 8;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWR = 2'b10;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  typedef struct packed {
    logic             v;
    logic [SB_AW-1:0] rw;
    logic             ld;
  } sb_entry_t;

  // m[0] is the EX entry (youngest), m[1] the MEM entry.
  function automatic logic [1:0] fwd_sel(input logic [1:0] m);
    if (m[0]) begin
      return FWD_EXMEM;
    end else if (m[1]) begin
      return FWD_MEMWR;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/pipe_hazard_sched_if.sv
// ID-stage / branch inputs and stall-flush-forward controls of the hazard
// scheduler; master is the core datapath, slave is the scheduler.
interface pipe_hazard_sched_if #(
  parameter int REG_AW = pipe_pkg::REG_AW_DEFAULT
) ();

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_reg_wr;
  logic [REG_AW-1:0] id_rw;
  logic              id_is_load;
  logic              ex_branch_taken;
  logic              pc_inc;
  logic              ifid_hold;
  logic              ifid_flush;
  logic              idex_bubble;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_reg_wr, id_rw, id_is_load, ex_branch_taken,
    input  pc_inc, ifid_hold, ifid_flush, idex_bubble, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_reg_wr, id_rw, id_is_load, ex_branch_taken,
    output pc_inc, ifid_hold, ifid_flush, idex_bubble, fwd_a, fwd_b
  );

endinterface

// File: rtl/pipe_hazard_sched_hz_match.sv
// Compares one ID source register against the EX/MEM/WR scoreboard entries;
// register 0 and unused sources never match.
module hz_match
  import pipe_pkg::*;
(
  input  logic                  used,
  input  logic [SB_AW-1:0]      src,
  input  sb_entry_t [2:0]       sb,
  output logic [2:0]            match
);

  // Per-entry match vector, index 0 = EX, 1 = MEM, 2 = WR.
  always_comb begin
    match = 3'b000;
    for (int i = 0; i < 3; i++) begin
      match[i] = sb[i].v & used & (sb[i].rw == src) & (src != {SB_AW{1'b0}});
    end
  end

endmodule

// File: rtl/pipe_hazard_sched.sv
// RAW-hazard stall / taken-branch flush scheduler for the 5-stage core.
// Define PIPE_FWD_EN to enable EX/MEM and MEM/WR forwarding (load-use stalls only).
module pipe_hazard_sched
  import pipe_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEFAULT,
  parameter int BR_PENALTY = 2
) (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_sched_if.slave  bus
);

  localparam int CNT_W = $clog2(BR_PENALTY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BR_PENALTY - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  sb_entry_t [2:0]  sb_r;
  logic [2:0]       m_rs_s;
  logic [2:0]       m_rt_s;
  logic             hz_s;
  logic             pc_inc_s;
  logic             hold_s;
  logic             flush_s;
  logic             bubble_s;
  logic [1:0]       fwd_a_r;
  logic [1:0]       fwd_b_r;

  hz_match u_match_rs (
    .used  (bus.id_uses_rs),
    .src   (SB_AW'(bus.id_rs)),
    .sb    (sb_r),
    .match (m_rs_s)
  );

  hz_match u_match_rt (
    .used  (bus.id_uses_rt),
    .src   (SB_AW'(bus.id_rt)),
    .sb    (sb_r),
    .match (m_rt_s)
  );

`ifdef PIPE_FWD_EN
  logic wr_match_unused_s;
  assign wr_match_unused_s = m_rs_s[2] ^ m_rt_s[2];
  assign hz_s = (m_rs_s[0] | m_rt_s[0]) & sb_r[0].ld;

  // Forward selects travel with the instruction into EX.
  always_ff @(negedge clk) begin
    if (reset) begin
      fwd_a_r <= FWD_RF;
      fwd_b_r <= FWD_RF;
    end else if (bubble_s || !bus.id_valid) begin
      fwd_a_r <= FWD_RF;
      fwd_b_r <= FWD_RF;
    end else begin
      fwd_a_r <= fwd_sel(m_rs_s[1:0]);
      fwd_b_r <= fwd_sel(m_rt_s[1:0]);
    end
  end
`else
  logic ld_unused_s;
  assign ld_unused_s = sb_r[0].ld ^ sb_r[1].ld ^ sb_r[2].ld;
  assign hz_s    = |{m_rs_s, m_rt_s};
  assign fwd_a_r = FWD_RF;
  assign fwd_b_r = FWD_RF;
`endif

  // Mealy controls: branch flush outranks the RAW stall.
  always_comb begin
    pc_inc_s = 1'b0;
    hold_s   = 1'b0;
    flush_s  = 1'b0;
    bubble_s = 1'b0;
    if (reset) begin
      pc_inc_s = 1'b0;
    end else if (bus.ex_branch_taken || (state_r == FLUSH)) begin
      pc_inc_s = 1'b1;
      flush_s  = 1'b1;
      bubble_s = 1'b1;
    end else if (hz_s) begin
      hold_s   = 1'b1;
      bubble_s = 1'b1;
    end else begin
      pc_inc_s = 1'b1;
    end
  end

  // Scoreboard shifts with the pipeline; a bubble enters EX as an invalid entry.
  always_ff @(negedge clk) begin
    if (reset) begin
      sb_r <= '{default: '0};
    end else begin
      sb_r[2] <= sb_r[1];
      sb_r[1] <= sb_r[0];
      if (bubble_s || !bus.id_valid) begin
        sb_r[0] <= '{default: '0};
      end else begin
        sb_r[0] <= '{v: bus.id_reg_wr, rw: SB_AW'(bus.id_rw), ld: bus.id_is_load};
      end
    end
  end

  // Control FSM with the post-branch flush countdown.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_r <= RUN;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        RUN, STALL: begin
          if (bus.ex_branch_taken) begin
            state_r <= FLUSH;
            cnt_r   <= CNT_LOAD;
          end else if (hz_s) begin
            state_r <= STALL;
          end else begin
            state_r <= RUN;
          end
        end
        FLUSH: begin
          if (bus.ex_branch_taken) begin
            cnt_r <= CNT_LOAD;
          end else if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= RUN;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= RUN;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.pc_inc      = pc_inc_s;
  assign bus.ifid_hold   = hold_s;
  assign bus.ifid_flush  = flush_s;
  assign bus.idex_bubble = bubble_s;
  assign bus.fwd_a       = reset ? FWD_RF : fwd_a_r;
  assign bus.fwd_b       = reset ? FWD_RF : fwd_b_r;

endmodule
